// File: rtl/fir_cas_pkg.sv
// fir_cas_pkg: shared widths, sfix8_En7 coefficients and tap-to-product mapping for the cascaded 19-tap FIR output stage
package fir_cas_pkg;
  localparam int NTAPS = 19;
  localparam int ACC_W = 20;
  localparam int OUT_W = 16;
  localparam int PROD_W = 16;
  localparam int FILL_W = 5;
  localparam logic signed [7:0] COEFF1 = 8'sd0;
  localparam logic signed [7:0] COEFF2 = 8'sd0;
  localparam logic signed [7:0] COEFF3 = -8'sd1;
  localparam logic signed [7:0] COEFF4 = 8'sd0;
  localparam logic signed [7:0] COEFF5 = 8'sd3;
  localparam logic signed [7:0] COEFF6 = 8'sd0;
  localparam logic signed [7:0] COEFF7 = -8'sd10;
  localparam logic signed [7:0] COEFF8 = 8'sd0;
  localparam logic signed [7:0] COEFF9 = 8'sd39;
  localparam logic signed [7:0] COEFF10 = 8'sd64;
  localparam logic signed [7:0] COEFF11 = 8'sd39;
  localparam logic signed [7:0] COEFF12 = 8'sd0;
  localparam logic signed [7:0] COEFF13 = -8'sd10;
  localparam logic signed [7:0] COEFF14 = 8'sd0;
  localparam logic signed [7:0] COEFF15 = 8'sd3;
  localparam logic signed [7:0] COEFF16 = 8'sd0;
  localparam logic signed [7:0] COEFF17 = -8'sd1;
  localparam logic signed [7:0] COEFF18 = 8'sd0;
  localparam logic signed [7:0] COEFF19 = 8'sd0;
  typedef enum logic [2:0] {SEL_NONE, SEL_10, SEL_11, SEL_13, SEL_15, SEL_17} prod_sel_e;
  function automatic prod_sel_e tap_sel(input int k);
    return (k == 10) ? SEL_10 :
           (k == 9 || k == 11) ? SEL_11 :
           (k == 7 || k == 13) ? SEL_13 :
           (k == 5 || k == 15) ? SEL_15 :
           (k == 3 || k == 17) ? SEL_17 : SEL_NONE;
  endfunction
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction
endpackage

// File: rtl/output_ctrl_cas_if.sv
// output_ctrl_cas_if: product/output bundle; master drives clk_enable and product10..17, slave drives filter_out and filter_out_valid
interface output_ctrl_cas_if;
  import fir_cas_pkg::*;
  logic clk_enable;
  logic signed [PROD_W-1:0] product10;
  logic signed [PROD_W-1:0] product11;
  logic signed [PROD_W-1:0] product13;
  logic signed [PROD_W-1:0] product15;
  logic signed [PROD_W-1:0] product17;
  logic signed [OUT_W-1:0] filter_out;
  logic filter_out_valid;
  modport master (output clk_enable, product10, product11, product13, product15, product17, input filter_out, filter_out_valid);
  modport slave (input clk_enable, product10, product11, product13, product15, product17, output filter_out, filter_out_valid);
endinterface

// File: rtl/cas_tap_stage.sv
// cas_tap_stage: one transposed-chain adder plus enabled register; ports clk, reset, en_i, a_i (upstream reg), b_i (tap product), q_o
module cas_tap_stage
  import fir_cas_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [ACC_W-1:0] b_i,
  output logic signed [ACC_W-1:0] q_o
);
  logic signed [ACC_W-1:0] sum_q;
  always_ff @(posedge clk)
    if (reset) sum_q <= '0;
    else if (en_i) sum_q <= a_i + b_i;
  assign q_o = sum_q;
endmodule

// File: rtl/output_ctrl_cas.sv
// output_ctrl_cas: transposed 19-tap FIR output end; ports clk, reset, bus (slave: clk_enable, product10..17 in, filter_out, filter_out_valid out); OUTPUT_CTRL_CAS_SAT_EN selects saturating output instead of wrap
module output_ctrl_cas
  import fir_cas_pkg::*;
(
  input logic clk,
  input logic reset,
  output_ctrl_cas_if.slave bus
);
  logic signed [ACC_W-1:0] prod [1:NTAPS];
  logic signed [ACC_W-1:0] r [1:NTAPS];
  logic signed [OUT_W-1:0] out_d, out_q;
  logic [FILL_W-1:0] cnt_d, cnt_q;
  logic valid_d, valid_q;
  genvar k;
  for (k = 1; k <= NTAPS; k++) begin : g_prod
    localparam prod_sel_e S = tap_sel(k);
    assign prod[k] = sext(S == SEL_10 ? bus.product10 :
                          S == SEL_11 ? bus.product11 :
                          S == SEL_13 ? bus.product13 :
                          S == SEL_15 ? bus.product15 :
                          S == SEL_17 ? bus.product17 : PROD_W'(0));
  end
  assign r[NTAPS] = '0;
  for (k = 1; k < NTAPS; k++) begin : g_stage
    cas_tap_stage u_stage (
      .clk  (clk),
      .reset(reset),
      .en_i (bus.clk_enable),
      .a_i  (r[k+1]),
      .b_i  (prod[k+1]),
      .q_o  (r[k])
    );
  end
`ifdef OUTPUT_CTRL_CAS_SAT_EN
  logic signed [ACC_W-1:0] acc;
  assign acc = r[1] + prod[1];
  assign out_d = (&acc[ACC_W-1:OUT_W-1] || ~|acc[ACC_W-1:OUT_W-1]) ? acc[OUT_W-1:0] :
                 {acc[ACC_W-1], {(OUT_W-1){~acc[ACC_W-1]}}};
`else
  assign out_d = OUT_W'(r[1] + prod[1]);
`endif
  assign cnt_d = (cnt_q == FILL_W'(NTAPS)) ? cnt_q : cnt_q + 1'b1;
  assign valid_d = valid_q || (cnt_q == FILL_W'(NTAPS - 1));
  always_ff @(posedge clk)
    if (reset) begin
      out_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
    end else if (bus.clk_enable) begin
      out_q <= out_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
    end
  assign bus.filter_out = out_q;
  assign bus.filter_out_valid = valid_q;
endmodule

// File: tb/tb_output_ctrl_cas.sv
// tb_output_ctrl_cas: directed self-checking bench for output_ctrl_cas
module tb_output_ctrl_cas;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int imp [1:19] = '{0, 0, -64, 0, 192, 0, -640, 0, 2496, 4096, 2496, 0, -640, 0, 192, 0, -64, 0, 0};
  int acc;
  output_ctrl_cas_if bus ();
  output_ctrl_cas dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic drive(input logic en, input int p10, input int p11, input int p13, input int p15, input int p17);
    bus.clk_enable = en;
    bus.product10 = 16'(p10);
    bus.product11 = 16'(p11);
    bus.product13 = 16'(p13);
    bus.product15 = 16'(p15);
    bus.product17 = 16'(p17);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    drive(1'b1, 1234, -777, 55, 9, -3);
    reset = 1'b1;
    tick();
    tick();
    chk("reset_out", bus.filter_out, 0);
    chk("reset_valid", {31'b0, bus.filter_out_valid}, 0);
    reset = 1'b0;
    for (int j = 1; j <= 19; j++) begin
      if (j == 1) drive(1'b1, 4096, 2496, -640, 192, -64);
      else drive(1'b1, 0, 0, 0, 0, 0);
      tick();
      chk($sformatf("imp_out[%0d]", j), bus.filter_out, imp[j]);
      chk($sformatf("imp_valid[%0d]", j), {31'b0, bus.filter_out_valid}, (j == 19) ? 1 : 0);
    end
    for (int j = 1; j <= 19; j++) begin
      if (j == 1) drive(1'b1, 4096, 2496, -640, 192, -64);
      else drive(1'b1, 0, 0, 0, 0, 0);
      tick();
      chk($sformatf("str_out[%0d]", j), bus.filter_out, imp[j]);
      drive(1'b0, 999, -999, 321, -123, 77);
      tick();
      chk($sformatf("str_hold[%0d]", j), bus.filter_out, imp[j]);
      chk($sformatf("str_valid[%0d]", j), {31'b0, bus.filter_out_valid}, 1);
    end
    reset = 1'b1;
    drive(1'b1, 4096, 2496, -640, 192, -64);
    tick();
    reset = 1'b0;
    acc = 0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j <= 19) acc += imp[j];
      chk($sformatf("step_out[%0d]", j), bus.filter_out, acc);
      chk($sformatf("step_valid[%0d]", j), {31'b0, bus.filter_out_valid}, (j >= 19) ? 1 : 0);
    end
    chk("step_final", bus.filter_out, 8064);
    reset = 1'b1;
    tick();
    chk("midrst_out", bus.filter_out, 0);
    chk("midrst_valid", {31'b0, bus.filter_out_valid}, 0);
    reset = 1'b0;
    acc = 0;
    for (int j = 1; j <= 19; j++) begin
      tick();
      acc += imp[j];
      chk($sformatf("rst_step_out[%0d]", j), bus.filter_out, acc);
      chk($sformatf("rst_step_valid[%0d]", j), {31'b0, bus.filter_out_valid}, (j >= 19) ? 1 : 0);
    end
    drive(1'b1, -8192, -4992, 1280, -384, 128);
    for (int j = 1; j <= 19; j++) begin
      tick();
      if (j >= 17) chk($sformatf("neg_out[%0d]", j), bus.filter_out, -16128);
    end
    drive(1'b1, 32767, 32767, 32767, 32767, 32767);
    for (int j = 1; j <= 19; j++) begin
      tick();
`ifdef OUTPUT_CTRL_CAS_SAT_EN
      if (j >= 17) chk($sformatf("max_out[%0d]", j), bus.filter_out, 32767);
`else
      if (j >= 17) chk($sformatf("max_out[%0d]", j), bus.filter_out, 32759);
`endif
    end
    chk("max_valid", {31'b0, bus.filter_out_valid}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
